lsu: RTL
========

# lsu

Load/store unit for the memory stage of the pipelined RV32I core, directly downstream of the execute-stage ALU. It consumes the ALU result (effective address or arithmetic result), store data and the funct3 of the instruction, and runs a single outstanding req/ack transaction on the data-memory port. It returns aligned, sign- or zero-extended load data (or the passed-through ALU result) to writeback. It stalls upstream while a transaction is in flight and flags misaligned or illegal accesses without touching memory.

## Interface
- DATA_WIDTH, 32: datapath and memory word width; only 32 is supported.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  an instruction is presented this cycle.
- mem_read / mem_write  in  1 / 1  load / store.
- reg_write  in  1  instruction writes rd.
- funct3  in  3  access size and sign.
- alu_res  in  32  effective address (mem op) or result (non-mem).
- store_data  in  32  rs2 value.
- rd_in  in  5  destination register.
- lsu_stall  out  1  upstream must hold; high whenever state is WAIT.
- dmem_req  out  1  request valid; held until ack.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned address (low 2 bits zero).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  request completes this cycle.
- dmem_rdata  in  32  read word; valid with ack.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- lsu_exc  out  1  one-cycle exception pulse.
- exc_cause  out  1  0 = misaligned, 1 = illegal access.
- exc_addr  out  32  faulting alu_res.

## Operation
- States: IDLE, WAIT. Reset: state IDLE. All registered outputs are 0 at reset. lsu_stall = (state==WAIT), so it is 0 at reset.
- **IDLE, ex_valid with neither read nor write**
  - If reg_write and rd_in!=0: next cycle wb_valid=1, wb_data=alu_res, wb_rd=rd_in.
  - Otherwise nothing is produced.
- **IDLE, ex_valid with a memory op — illegal checks**
  - Illegal if both read and write are set.
  - Illegal for loads if funct3 is 011, 110 or 111.
  - Illegal for stores if funct3 is anything other than 000, 001 or 010.
  - Illegal: next cycle lsu_exc=1, exc_cause=1, exc_addr=alu_res. No request.
- **IDLE, memory op — alignment check**
  - Misaligned if a halfword access has addr[0]=1, or a word access has addr[1:0]!=0.
  - Misaligned: next cycle lsu_exc=1, exc_cause=0, exc_addr=alu_res. No request. State stays IDLE.
- **IDLE, memory op — accept**
  - Otherwise the access is accepted. Latch funct3, addr[1:0], rd_in and the read/write type.
  - Next cycle: dmem_req=1, dmem_addr={alu_res[31:2],2'b00}, dmem_we=mem_write. State goes to WAIT.
- **Store lanes**
  - SB: wdata = byte replicated ×4; be = 1<<addr[1:0].
  - SH: wdata = half replicated ×2; be = 0011 (addr[1]=0) or 1100.
  - SW: wdata = store_data; be = 1111.
  - Loads: be = 1111, wdata = 0.
- **WAIT**
  - ex_* inputs are ignored. dmem_req and the request fields stay stable until dmem_ack.
  - On the ack cycle: dmem_req drops next cycle and state returns to IDLE.
  - For loads with rd!=0, next cycle wb_valid=1 with extracted data.
- **Load extraction** (byte/half selected by the latched addr bits)
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: whole word.
  - Stores and rd=0 loads produce no wb_valid.
- wb_valid and lsu_exc are single-cycle pulses. wb_data, wb_rd and exc_addr hold their last value otherwise.
- Reset asserted mid-WAIT: immediate return to IDLE, dmem_req=0, all outputs 0. A late ack is ignored.

## Timing
- Accept at cycle T (lsu_stall=0 at T).
- dmem_req rises at T+1; lsu_stall=1 from T+1.
- Ack is allowed in the same cycle as req (earliest T+1).
- Ack at cycle A: wb_valid at A+1, dmem_req=0 at A+1, lsu_stall=0 at A+1, and a new accept is possible at A+1.
- Minimum load latency is 2 cycles, with one memory op every 2 cycles at best.
- Non-mem passthrough and exceptions: 1-cycle latency, no stall, back-to-back every cycle.
- dmem_ack seen in IDLE: ignored.

## Test plan
- **Load with delay:** LW, alu_res=0x0000_1008, rd=5; ack 3 cycles after req with rdata=0xDEAD_BEEF.
  - Expect dmem_addr=0x1008 and be=1111.
  - Expect lsu_stall high until ack.
  - Expect wb_valid one cycle after ack with wb_data=0xDEADBEEF, wb_rd=5.
- **Byte load sign and zero extension:**
  - LB at 0x103 with rdata=0x80FF_FF00 -> wb_data=0xFFFF_FF80.
  - Repeat as LBU -> 0x0000_0080.
  - LHU at 0x102 with rdata=0x8001_0000 -> 0x0000_8001.
- **Halfword store:** SH, alu_res=0x0000_2002, store_data=0x1234_ABCD.
  - Expect dmem_we=1, addr=0x2000, wdata=0xABCD_ABCD, be=1100.
  - No wb_valid.
- **Misaligned and illegal accesses:**
  - LW at 0x0000_1002: no dmem_req; next-cycle lsu_exc=1, exc_cause=0, exc_addr=0x1002.
  - Load with funct3=011: lsu_exc=1, exc_cause=1.
- **Back-to-back with same-cycle ack:** two loads plus ALU ops, with ack asserted in the same cycle as req.
  - Expect accepts exactly every 2 cycles for the loads.
  - Passthrough ALU ops give wb_valid each cycle; rd=0 gives no wb_valid.
- **Reset mid-transaction:** rst_n low during WAIT.
  - Expect dmem_req=0 immediately and state IDLE.
  - An ack arriving after reset is released produces no wb_valid.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit for the RV32I memory stage: one outstanding req/ack
// transaction on the data port, ALU-result passthrough, and precise
// misaligned/illegal-access reporting without touching memory.
module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid_i,
    input  logic                    mem_read_i,
    input  logic                    mem_write_i,
    input  logic                    reg_write_i,
    input  logic [2:0]              funct3_i,
    input  logic [DATA_WIDTH-1:0]   alu_res_i,
    input  logic [DATA_WIDTH-1:0]   store_data_i,
    input  logic [4:0]              rd_in_i,
    output logic                    lsu_stall_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [DATA_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    output logic [3:0]              dmem_be_o,
    input  logic                    dmem_ack_i,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
    output logic                    wb_valid_o,
    output logic [4:0]              wb_rd_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    output logic                    lsu_exc_o,
    output logic                    exc_cause_o,
    output logic [DATA_WIDTH-1:0]   exc_addr_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [DATA_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]              dmem_be_q, dmem_be_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [4:0]              wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    lsu_exc_q, lsu_exc_d;
    logic                    exc_cause_q, exc_cause_d;
    logic [DATA_WIDTH-1:0]   exc_addr_q, exc_addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic [4:0]              rd_q, rd_d;

    logic                    is_mem;
    logic                    illegal;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   st_wdata;
    logic [3:0]              st_be;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_data;

    // Classify the presented instruction: memory op, illegal encoding, misalignment.
    always_comb begin
        is_mem     = mem_read_i | mem_write_i;
        illegal    = (mem_read_i & mem_write_i)
                   | (mem_read_i & ((funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111)))
                   | (mem_write_i & (funct3_i > 3'b010));
        misaligned = ((funct3_i[1:0] == 2'b01) & alu_res_i[0])
                   | ((funct3_i[1:0] == 2'b10) & (alu_res_i[1:0] != 2'b00));
    end

    // Store lane replication and byte enables; loads read the full word.
    always_comb begin
        st_wdata = store_data_i;
        st_be    = 4'b1111;
        if (mem_read_i) begin
            st_wdata = '0;
        end else begin
            case (funct3_i[1:0])
                2'b00: begin
                    st_wdata = {4{store_data_i[7:0]}};
                    st_be    = 4'b0001 << alu_res_i[1:0];
                end
                2'b01: begin
                    st_wdata = {2{store_data_i[15:0]}};
                    st_be    = alu_res_i[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        load_data = dmem_rdata_i;
        byte_sel  = dmem_rdata_i[{off_q, 3'b000} +: 8];
        half_sel  = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/WAIT controller.
    always_comb begin
        // NOTE: every _d gets a default before any branch; a path that leaves
        // one unassigned would infer a latch instead of a flop input.
        state_d      = state_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        lsu_exc_d    = 1'b0;
        exc_cause_d  = exc_cause_q;
        exc_addr_d   = exc_addr_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;

        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!is_mem) begin
                        if (reg_write_i && (rd_in_i != 5'd0)) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = rd_in_i;
                            wb_data_d  = alu_res_i;
                        end
                    end else if (illegal || misaligned) begin
                        // Illegal encoding takes priority over alignment.
                        lsu_exc_d   = 1'b1;
                        exc_cause_d = illegal;
                        exc_addr_d  = alu_res_i;
                    end else begin
                        state_d      = WAIT;
                        dmem_we_d    = mem_write_i;
                        dmem_addr_d  = {alu_res_i[DATA_WIDTH-1:2], 2'b00};
                        dmem_wdata_d = st_wdata;
                        dmem_be_d    = st_be;
                        funct3_d     = funct3_i;
                        off_d        = alu_res_i[1:0];
                        rd_d         = rd_in_i;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack_i) begin
                    state_d = IDLE;
                    if (!dmem_we_q && (rd_q != 5'd0)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            lsu_exc_q    <= 1'b0;
            exc_cause_q  <= 1'b0;
            exc_addr_q   <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            lsu_exc_q    <= lsu_exc_d;
            exc_cause_q  <= exc_cause_d;
            exc_addr_q   <= exc_addr_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
        end
    end

    // The request is outstanding exactly while the controller waits.
    assign lsu_stall_o  = (state_q == WAIT);
    assign dmem_req_o   = (state_q == WAIT);
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign dmem_be_o    = dmem_be_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign lsu_exc_o    = lsu_exc_q;
    assign exc_cause_o  = exc_cause_q;
    assign exc_addr_o   = exc_addr_q;

endmodule
